// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Parametrised integer register file with a post-reset clear
//             sweep, a per-register pending-write scoreboard and optional
//             write-to-read bypass.
//             Optional feature macro: REGFILE_BYPASS_EN
//               defined   -> a same-cycle write is forwarded to matching reads
//               undefined -> reads always return the stored contents
//  Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NREAD    = 2,
    parameter int              SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_INIT  = XLEN'(32'h3fc),
    localparam int             AW       = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeRegister,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       dataToWrite,
    input  logic                  reserve,
    input  logic [AW-1:0]         rsv_rd,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] readData,
    output logic [NREAD-1:0]      readBusy,
    output logic                  ready
);

    // Sweep index terminal value; one extra bit lets the index reach NREGS
    // without wrapping back to zero.
    localparam logic [AW:0] c_sweep_end = (AW+1)'(NREGS);
    localparam logic [AW:0] c_idx_one   = (AW+1)'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [AW:0]          idx_q;
    logic [AW:0]          idx_d;
    logic [AW:0]          w_idx_inc;
    logic [XLEN-1:0]      regs_q [NREGS];
    logic [NREGS-1:0]     busy_q;
    logic [NREGS-1:0]     busy_d;
    logic [XLEN-1:0]      w_sweep_val;
    logic                 w_run;
    logic                 w_wr_en;
    logic                 w_rsv_en;

    // Writes and reserves only take effect once the file is usable, and
    // register 0 is hard-wired, so it never takes data or a reservation.
    assign w_run     = (state_q == ST_RUN);
    assign w_wr_en   = w_run && writeRegister && (rd != '0);
    assign w_rsv_en  = w_run && reserve && (rsv_rd != '0);
    assign w_idx_inc = idx_q + c_idx_one;
    assign ready     = w_run;

    // The stack pointer register is seeded during the sweep; all others zero.
    assign w_sweep_val = (idx_q[AW-1:0] == AW'(SP_INDEX)) ? SP_INIT : '0;

    // Next-state logic: sweep every register once, then stay in RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = w_idx_inc;
                if (w_idx_inc == c_sweep_end) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Scoreboard update: a write retires its register, a reserve marks it
    // pending; reserve is applied last so a new producer wins a collision.
    always_comb begin
        busy_d = busy_q;
        if (w_wr_en) begin
            busy_d[rd] = 1'b0;
        end
        if (w_rsv_en) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control state and scoreboard registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: no reset of its own, the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                regs_q[idx_q[AW-1:0]] <= w_sweep_val;
            end else if (w_wr_en) begin
                regs_q[rd] <= dataToWrite;
            end
        end
    end

    // Independent combinational read ports.
    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = rs[p*AW +: AW];

        // Read mux: quiet while clearing, register 0 always reads zero.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_run && (w_addr != '0)) begin
                w_data = regs_q[w_addr];
                w_busy = busy_q[w_addr];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_en && (w_addr == rd)) begin
                    w_data = dataToWrite;
                    w_busy = w_rsv_en && (rsv_rd == w_addr);
                end
`endif
            end
        end

        assign readData[p*XLEN +: XLEN] = w_data;
        assign readBusy[p]              = w_busy;
    end

endmodule
`default_nettype wire
